// File: rtl/regfile_wb_sink_if.sv
// Register-file sink bus: operand reads, writeback, reservations.
// Datapath drives as master; regfile_wb_sink consumes as slave.
interface regfile_wb_sink_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rs1_en;
  logic [ADDR_W-1:0] rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic              rs2_en;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              stall;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rs1_en, rs1_addr,
    output rs2_en, rs2_addr,
    output wb_en, wb_addr, wb_data,
    output rsv_en, rsv_addr,
    input  rs1_data, rs2_data,
    input  stall, busy_cnt
  );

  modport slave (
    input  rs1_en, rs1_addr,
    input  rs2_en, rs2_addr,
    input  wb_en, wb_addr, wb_data,
    input  rsv_en, rsv_addr,
    output rs1_data, rs2_data,
    output stall, busy_cnt
  );
endinterface

// File: rtl/regfile_wb_sink.sv
// Register file with writeback sink and busy scoreboard.
// Optional: RF_BYPASS_EN forwards wb_data to reads and stall.
module regfile_wb_sink #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           rst_n,
  regfile_wb_sink_if.slave bus
);

  localparam int N     = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] idx_t;
  typedef logic [DATA_W-1:0] word_t;

  word_t            rf_q [N];
  word_t            rf_d [N];
  logic [N-1:0]     busy_q;
  logic [N-1:0]     busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [N-1:0] wb_dec;
  logic [N-1:0] rsv_dec;
  logic [N-1:0] busy_view;
  logic         wr_ok;
  logic         set_ok;
  logic         inc;
  logic         dec;

  function automatic logic is_zero(idx_t a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic word_t rd(idx_t a);
    word_t v;
    v = rf_q[a];
`ifdef RF_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a)
      v = bus.wb_data;
`endif
    if (is_zero(a))
      v = '0;
    return v;
  endfunction

  // Qualified strobes and one-hot decode of write/reserve indices
  always_comb begin
    wr_ok   = bus.wb_en & ~is_zero(bus.wb_addr);
    set_ok  = bus.rsv_en & ~is_zero(bus.rsv_addr);
    wb_dec  = '0;
    rsv_dec = '0;
    if (bus.wb_en)
      wb_dec[bus.wb_addr] = 1'b1;
    if (set_ok)
      rsv_dec[bus.rsv_addr] = 1'b1;
  end

  // Next register contents: one write per cycle
  always_comb begin
    rf_d = rf_q;
    if (wr_ok)
      rf_d[bus.wb_addr] = bus.wb_data;
  end

  // Next busy bits: retire first, then a new reservation wins
  always_comb begin
    busy_d = (busy_q & ~wb_dec) | rsv_dec;
  end

  // Incremental population count, never below the live bit count
  always_comb begin
    inc   = set_ok & ~busy_q[bus.rsv_addr];
    dec   = bus.wb_en & busy_q[bus.wb_addr]
          & ~(set_ok & (bus.rsv_addr == bus.wb_addr));
    cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
  end

  // Busy view for stall; bypass treats retiring regs as free
  always_comb begin
`ifdef RF_BYPASS_EN
    busy_view = busy_q & ~wb_dec;
`else
    busy_view = busy_q;
`endif
  end

  // Operand reads and hazard detection
  always_comb begin
    bus.rs1_data = rd(bus.rs1_addr);
    bus.rs2_data = rd(bus.rs2_addr);
    bus.busy_cnt = cnt_q;
    bus.stall =
        (bus.rs1_en & busy_view[bus.rs1_addr]
         & ~is_zero(bus.rs1_addr))
      | (bus.rs2_en & busy_view[bus.rs2_addr]
         & ~is_zero(bus.rs2_addr))
      | (bus.rsv_en & busy_view[bus.rsv_addr]
         & ~is_zero(bus.rsv_addr));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        rf_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        rf_q[i] <= rf_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Randomised + directed bench for regfile_wb_sink.
// Reference model: plain arrays updated from the behavioural rules.
module tb_regfile_wb_sink;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_wb_sink_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_sink #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [31:0] m_rf [32];
  logic [31:0] m_busy;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
`endif
    return m_rf[a];
  endfunction

  function automatic logic m_stall();
    logic [31:0] v;
    v = m_busy;
`ifdef RF_BYPASS_EN
    if (bus.wb_en) v[bus.wb_addr] = 1'b0;
`endif
    return (bus.rs1_en && v[bus.rs1_addr])
        || (bus.rs2_en && v[bus.rs2_addr])
        || (bus.rsv_en && v[bus.rsv_addr]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_busy = 32'h0;
  endtask

  task automatic idle();
    bus.rs1_en = 0; bus.rs1_addr = 0;
    bus.rs2_en = 0; bus.rs2_addr = 0;
    bus.wb_en = 0;  bus.wb_addr = 0; bus.wb_data = 0;
    bus.rsv_en = 0; bus.rsv_addr = 0;
  endtask

  // Check against model, take the edge, update model
  task automatic tick();
    #1;
    check("rs1_data", bus.rs1_data, m_read(bus.rs1_addr));
    check("rs2_data", bus.rs2_data, m_read(bus.rs2_addr));
    check("stall", bus.stall, m_stall());
    check("busy_cnt", bus.busy_cnt, $countones(m_busy));
    @(posedge clk);
    if (!rst_n) begin
      m_clear();
    end else begin
      if (bus.wb_en && bus.wb_addr != 0)
        m_rf[bus.wb_addr] = bus.wb_data;
      if (bus.wb_en) m_busy[bus.wb_addr] = 1'b0;
      if (bus.rsv_en && bus.rsv_addr != 0)
        m_busy[bus.rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    m_clear();
    idle();
    @(negedge clk);
    #1;
    check("rst_cnt", bus.busy_cnt, 0);
    check("rst_stall", bus.stall, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // write r5, read in write cycle and the next
    bus.wb_en = 1; bus.wb_addr = 5;
    bus.wb_data = 32'hDEADBEEF;
    bus.rs1_addr = 5;
    #1;
`ifdef RF_BYPASS_EN
    check("r5_same", bus.rs1_data, 32'hDEADBEEF);
`else
    check("r5_same", bus.rs1_data, 0);
`endif
    tick();
    idle(); bus.rs1_addr = 5;
    #1;
    check("r5_next", bus.rs1_data, 32'hDEADBEEF);
    tick();

    // r0 hardwired
    bus.wb_en = 1; bus.wb_addr = 0;
    bus.wb_data = 32'h12345678;
    bus.rsv_en = 1; bus.rsv_addr = 0;
    tick();
    idle(); bus.rs2_en = 1; bus.rs2_addr = 0;
    #1;
    check("r0_read", bus.rs2_data, 0);
    check("r0_stall", bus.stall, 0);
    check("r0_cnt", bus.busy_cnt, 0);
    tick();

    // load-use on r7
    idle(); bus.rsv_en = 1; bus.rsv_addr = 7;
    tick();
    idle(); bus.rs1_en = 1; bus.rs1_addr = 7;
    #1;
    check("r7_stall", bus.stall, 1);
    check("r7_cnt", bus.busy_cnt, 1);
    bus.wb_en = 1; bus.wb_addr = 7;
    bus.wb_data = 32'hA5A5A5A5;
    #1;
`ifdef RF_BYPASS_EN
    check("r7_wb_stall", bus.stall, 0);
`else
    check("r7_wb_stall", bus.stall, 1);
`endif
    tick();
    idle(); bus.rs1_en = 1; bus.rs1_addr = 7;
    #1;
    check("r7_free", bus.stall, 0);
    check("r7_cnt0", bus.busy_cnt, 0);
    check("r7_data", bus.rs1_data, 32'hA5A5A5A5);
    tick();

    // same-index set+clear: set wins
    idle(); bus.rsv_en = 1; bus.rsv_addr = 3;
    tick();
    idle(); bus.rsv_en = 1; bus.rsv_addr = 3;
    bus.wb_en = 1; bus.wb_addr = 3; bus.wb_data = 32'h33;
    tick();
    idle(); bus.rs1_en = 1; bus.rs1_addr = 3;
    #1;
    check("r3_busy", bus.stall, 1);
    check("r3_cnt", bus.busy_cnt, 1);
    tick();

    // different-index set+clear
    idle(); bus.rsv_en = 1; bus.rsv_addr = 9;
    tick();
    idle(); bus.rsv_en = 1; bus.rsv_addr = 4;
    bus.wb_en = 1; bus.wb_addr = 9; bus.wb_data = 32'h99;
    tick();
    idle(); bus.rs1_en = 1; bus.rs1_addr = 4;
    bus.rs2_en = 1; bus.rs2_addr = 9;
    #1;
    check("r4r9_cnt", bus.busy_cnt, 2);
    check("r4_busy", bus.stall, 1);
    bus.rs1_en = 0;
    #1;
    check("r9_free", bus.stall, 0);
    tick();

    // write-after-write hazard
    idle(); bus.rsv_en = 1; bus.rsv_addr = 10;
    tick();
    idle(); bus.rsv_en = 1; bus.rsv_addr = 10;
    #1;
    check("waw_stall", bus.stall, 1);
    tick();

    // reservations then mid-cycle reset
    idle(); bus.wb_en = 1; bus.wb_addr = 1;
    bus.wb_data = 32'h11;
    tick();
    idle(); bus.rsv_en = 1; bus.rsv_addr = 1;
    tick();
    bus.rsv_addr = 2; tick();
    bus.rsv_addr = 3; tick();
    idle(); bus.rs1_addr = 1;
    #1;
    check("pre_rst_cnt", bus.busy_cnt, $countones(m_busy));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", bus.busy_cnt, 0);
    check("mid_rst_rd", bus.rs1_data, 0);
    check("mid_rst_stall", bus.stall, 0);
    m_clear();
    rst_n = 1'b1;
    bus.wb_en = 1; bus.wb_addr = 2; bus.wb_data = 32'h22;
    tick();
    idle(); bus.rs1_addr = 2;
    #1;
    check("post_rst_cnt", bus.busy_cnt, 0);
    check("post_rst_r2", bus.rs1_data, 32'h22);
    tick();

    // randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.rs1_en   = 1'($urandom_range(0, 1));
      bus.rs1_addr = 5'($urandom_range(0, 11));
      bus.rs2_en   = 1'($urandom_range(0, 1));
      bus.rs2_addr = 5'($urandom_range(0, 11));
      bus.wb_en    = ($urandom_range(0, 9) < 5);
      bus.wb_addr  = 5'($urandom_range(0, 11));
      bus.wb_data  = $urandom;
      bus.rsv_en   = ($urandom_range(0, 9) < 3);
      bus.rsv_addr = 5'($urandom_range(0, 11));
      if (n % 8 == 0) bus.wb_addr = bus.rsv_addr;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
